// File: rtl/character_ctl.sv
// character_ctl
//   Per-frame motion controller for the player character. Horizontal walk and
//   jump/gravity physics advance once per video frame, on the clk edge where a
//   rising edge of vsync_in is first seen. xpos/ypos are registered and serve
//   as the sprite anchor for the downstream draw stage.
//
//   Optional feature: define CHARACTER_DOUBLE_JUMP_EN to allow one extra jump
//   per airtime (adds a dj_used register). Without it, airborne jumps are
//   ignored.
//
// Ports
//   clk        in   pixel clock (only clock)
//   rst        in   asynchronous, active-low reset
//   module_en  in   1 = physics runs, 0 = all motion frozen
//   vsync_in   in   vsync from the VGA timing bus
//   jump_btn   in   jump request (level or single-clk pulse)
//   left_btn   in   walk left (level)
//   right_btn  in   walk right (level)
//   xpos       out  character x in px (registered)
//   ypos       out  character y in px (registered, larger = lower)
//   airborne   out  1 while not on the ground
//   landed     out  one-clk pulse on the landing tick
module character_ctl #(
  parameter int unsigned X_START  = 375,
  parameter int unsigned Y_GROUND = 425,
  parameter int unsigned Y_MIN    = 0,
  parameter int unsigned X_MIN    = 0,
  parameter int unsigned X_MAX    = 1023,
  parameter int unsigned H_STEP   = 4,
  parameter int unsigned JUMP_V0  = 12,
  parameter int unsigned GRAVITY  = 1,
  parameter int unsigned V_MAX    = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        module_en,
  input  logic        vsync_in,
  input  logic        jump_btn,
  input  logic        left_btn,
  input  logic        right_btn,
  output logic [10:0] xpos,
  output logic [10:0] ypos,
  output logic        airborne,
  output logic        landed
);

  localparam logic [1:0] ST_GROUND  = 2'd0;
  localparam logic [1:0] ST_ASCEND  = 2'd1;
  localparam logic [1:0] ST_DESCEND = 2'd2;

  // 12-bit working constants so position arithmetic never wraps.
  localparam logic [11:0] XMIN_W = 12'(X_MIN);
  localparam logic [11:0] XMAX_W = 12'(X_MAX);
  localparam logic [11:0] HSTP_W = 12'(H_STEP);
  localparam logic [11:0] YMIN_W = 12'(Y_MIN);
  localparam logic [11:0] YGND_W = 12'(Y_GROUND);
  localparam logic [11:0] GRAV_W = 12'(GRAVITY);
  localparam logic [11:0] VMAX_W = 12'(V_MAX);
  localparam logic [7:0]  JV0_V  = 8'(JUMP_V0);
  localparam logic [7:0]  GRAV_V = 8'(GRAVITY);
  localparam logic [7:0]  VMAX_V = 8'(V_MAX);

  logic        vsync_d_q, vsync_d_d;
  logic        jump_latch_q, jump_latch_d;
  logic [1:0]  state_q, state_d;
  logic [7:0]  vel_q, vel_d;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        airborne_q, airborne_d;
  logic        landed_q, landed_d;
`ifdef CHARACTER_DOUBLE_JUMP_EN
  logic        dj_used_q, dj_used_d;
`endif

  logic        tick;
  logic        jump_req;
  logic        dj_fire;
  logic [11:0] x_ext, y_ext, vel_ext;
  logic [11:0] vel_up_raw;
  logic [7:0]  vel_up;
  logic [11:0] y_dn;

  always_comb begin
    tick      = vsync_in & ~vsync_d_q;
    vsync_d_d = vsync_in;
    // A press on the tick clk itself is consumed by that tick rather than
    // being wiped by the latch clear, so a 1-clk pulse is never lost.
    jump_req  = jump_latch_q | jump_btn;

    x_ext      = {1'b0, x_q};
    y_ext      = {1'b0, y_q};
    vel_ext    = {4'b0, vel_q};
    vel_up_raw = vel_ext + GRAV_W;
    vel_up     = (vel_up_raw > VMAX_W) ? VMAX_V : vel_up_raw[7:0];
    y_dn       = y_ext + {4'b0, vel_up};

`ifdef CHARACTER_DOUBLE_JUMP_EN
    dj_fire = jump_req & ~dj_used_q & (state_q != ST_GROUND);
`else
    dj_fire = 1'b0;
`endif

    x_d          = x_q;
    y_d          = y_q;
    vel_d        = vel_q;
    state_d      = state_q;
    airborne_d   = airborne_q;
    landed_d     = 1'b0;
    jump_latch_d = jump_latch_q | jump_btn;
`ifdef CHARACTER_DOUBLE_JUMP_EN
    dj_used_d    = dj_used_q;
`endif

    if (!module_en) begin
      jump_latch_d = 1'b0;
    end else if (tick) begin
      jump_latch_d = 1'b0;

      if (left_btn && !right_btn) begin
        x_d = (x_ext < XMIN_W + HSTP_W) ? 11'(X_MIN) : 11'(x_ext - HSTP_W);
      end else if (right_btn && !left_btn) begin
        x_d = (x_ext + HSTP_W > XMAX_W) ? 11'(X_MAX) : 11'(x_ext + HSTP_W);
      end

      case (state_q)
        ST_GROUND: begin
          if (jump_req) begin
            state_d = ST_ASCEND;
            vel_d   = JV0_V;
          end
        end
        ST_ASCEND: begin
          if (dj_fire) begin
            vel_d = JV0_V;
          end else if (y_ext < YMIN_W + vel_ext) begin
            y_d     = 11'(Y_MIN);
            vel_d   = '0;
            state_d = ST_DESCEND;
          end else begin
            y_d = 11'(y_ext - vel_ext);
            if (vel_q <= GRAV_V) begin
              vel_d   = '0;
              state_d = ST_DESCEND;
            end else begin
              vel_d = vel_q - GRAV_V;
            end
          end
        end
        ST_DESCEND: begin
          if (dj_fire) begin
            vel_d   = JV0_V;
            state_d = ST_ASCEND;
          end else if (y_dn >= YGND_W) begin
            y_d      = 11'(Y_GROUND);
            vel_d    = '0;
            state_d  = ST_GROUND;
            landed_d = 1'b1;
          end else begin
            y_d   = y_dn[10:0];
            vel_d = vel_up;
          end
        end
        default: begin
          state_d = ST_GROUND;
          vel_d   = '0;
        end
      endcase

      airborne_d = (state_d != ST_GROUND);
`ifdef CHARACTER_DOUBLE_JUMP_EN
      if (state_d == ST_GROUND) begin
        dj_used_d = 1'b0;
      end else if (dj_fire) begin
        dj_used_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_d_q    <= 1'b0;
      jump_latch_q <= 1'b0;
      state_q      <= ST_GROUND;
      vel_q        <= '0;
      x_q          <= 11'(X_START);
      y_q          <= 11'(Y_GROUND);
      airborne_q   <= 1'b0;
      landed_q     <= 1'b0;
`ifdef CHARACTER_DOUBLE_JUMP_EN
      dj_used_q    <= 1'b0;
`endif
    end else begin
      vsync_d_q    <= vsync_d_d;
      jump_latch_q <= jump_latch_d;
      state_q      <= state_d;
      vel_q        <= vel_d;
      x_q          <= x_d;
      y_q          <= y_d;
      airborne_q   <= airborne_d;
      landed_q     <= landed_d;
`ifdef CHARACTER_DOUBLE_JUMP_EN
      dj_used_q    <= dj_used_d;
`endif
    end
  end

  assign xpos     = x_q;
  assign ypos     = y_q;
  assign airborne = airborne_q;
  assign landed   = landed_q;

endmodule
